// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
//   master : controller side; drives start, a, b, borrow_in.
//   slave  : subtractor side; drives busy, done, diff, borrow_out, overflow.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
  logic             overflow;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out, overflow
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Ports:
//   clk    : system clock, rising edge.
//   reset  : synchronous active-high reset.
//   sub_if : slave side of serial_subtractor_if (start/operands in,
//            busy/done/diff/borrow_out/overflow out).
// Results are registered only on the edge entering StDone, so diff never shows
// partial sums and holds through IDLE and the next SHIFT phase.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  serial_subtractor_if.slave sub_if
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt   = CntW'(WIDTH - 1);
  localparam logic [CntW-1:0] MsbInCnt  = CntW'(WIDTH - 2);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             br_msb_q, br_msb_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_shifted;

  // Full-subtractor cell on the current LSBs.
  assign d_bit       = a_sh_q[0] ^ b_sh_q[0] ^ br_q;
  assign br_next     = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & br_q);
  assign res_shifted = {d_bit, res_q[WIDTH-1:1]};

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    br_d     = br_q;
    br_msb_d = br_msb_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    ovf_d    = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (sub_if.start) begin
          a_sh_d  = sub_if.a;
          b_sh_d  = sub_if.b;
          br_d    = sub_if.borrow_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        res_d  = res_shifted;
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        br_d   = br_next;
        cnt_d  = cnt_q + 1'b1;
        // Borrow into the MSB, needed for signed overflow detection.
        if (cnt_q == MsbInCnt) begin
          br_msb_d = br_next;
        end
        if (cnt_q == LastCnt) begin
          diff_d   = res_shifted;
          borrow_d = br_next;
          ovf_d    = br_msb_q ^ br_next;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      br_q     <= 1'b0;
      br_msb_q <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      br_q     <= br_d;
      br_msb_q <= br_msb_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
    end
  end

  assign sub_if.busy       = (state_q != StIdle);
  assign sub_if.done       = (state_q == StDone);
  assign sub_if.diff       = diff_q;
  assign sub_if.borrow_out = borrow_q;
  assign sub_if.overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int unsigned W = 8;
  localparam int          Mod = 1 << W;
  localparam int          Half = 1 << (W - 1);

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  serial_subtractor_if #(.WIDTH(W)) sub_if ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .sub_if (sub_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic int ref_diff(input int a, input int b, input int bin);
    return ((a - b - bin) % Mod + Mod) % Mod;
  endfunction

  function automatic int ref_borrow(input int a, input int b, input int bin);
    return (a < b + bin) ? 1 : 0;
  endfunction

  function automatic int ref_ovf(input int a, input int b, input int bin);
    int sa, sb, r;
    sa = (a >= Half) ? a - Mod : a;
    sb = (b >= Half) ? b - Mod : b;
    r  = sa - sb - bin;
    return (r < -Half || r > Half - 1) ? 1 : 0;
  endfunction

  // One operation with a single-cycle start; checks latency, busy length,
  // diff stability during SHIFT and the final results.
  task automatic run_op(input int a, input int b, input int bin, input string tag);
    logic [W-1:0] prev_diff;
    int           busy_cnt;
    int           done_edge;
    prev_diff = sub_if.diff;
    @(negedge clk);
    sub_if.start     = 1'b1;
    sub_if.a         = W'(a);
    sub_if.b         = W'(b);
    sub_if.borrow_in = 1'(bin);
    @(posedge clk);
    #1;
    sub_if.start = 1'b0;
    sub_if.a     = W'($urandom);
    sub_if.b     = W'($urandom);
    busy_cnt  = 0;
    done_edge = -1;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      if (sub_if.busy) busy_cnt++;
      if (sub_if.done) begin
        done_edge = n;
        break;
      end
      if (sub_if.diff !== prev_diff) check_val({tag, "_stable"}, 32'(sub_if.diff), 32'(prev_diff));
    end
    check_val({tag, "_latency"}, 32'(done_edge), 32'(W));
    check_val({tag, "_busycnt"}, 32'(busy_cnt), 32'(W + 1));
    check_val({tag, "_diff"}, 32'(sub_if.diff), 32'(ref_diff(a, b, bin)));
    check_val({tag, "_borrow"}, 32'(sub_if.borrow_out), 32'(ref_borrow(a, b, bin)));
    check_val({tag, "_ovf"}, 32'(sub_if.overflow), 32'(ref_ovf(a, b, bin)));
    @(posedge clk);
    #1;
    check_val({tag, "_done_pulse"}, 32'({sub_if.done, sub_if.busy}), 32'(0));
  endtask

  initial begin
    int a_hist[64];
    int b_hist[64];
    int done_t[$];
    int ra, rb, rbin;

    n_checks = 0;
    n_errors = 0;
    sub_if.start     = 1'b0;
    sub_if.a         = '0;
    sub_if.b         = '0;
    sub_if.borrow_in = 1'b0;
    reset            = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("rst_busy", 32'(sub_if.busy), 0);
    check_val("rst_done", 32'(sub_if.done), 0);
    check_val("rst_diff", 32'(sub_if.diff), 0);
    check_val("rst_flags", 32'({sub_if.borrow_out, sub_if.overflow}), 0);

    run_op(32'h5A, 32'h23, 0, "t1");
    run_op(32'h00, 32'h01, 0, "t2");
    run_op(32'h80, 32'h01, 0, "t3a");
    run_op(32'h80, 32'h00, 1, "t3b");
    run_op(32'h10, 32'h10, 1, "t4");
    run_op(32'h7F, 32'hFF, 0, "edge_pos");
    run_op(32'h00, 32'hFF, 1, "edge_zero");

    // Start held high with operands changing every cycle.
    @(negedge clk);
    sub_if.start     = 1'b1;
    sub_if.borrow_in = 1'b0;
    for (int c = 0; c <= 2 * W + 3; c++) begin
      a_hist[c] = int'($urandom_range(Mod - 1, 0));
      b_hist[c] = int'($urandom_range(Mod - 1, 0));
      sub_if.a  = W'(a_hist[c]);
      sub_if.b  = W'(b_hist[c]);
      @(posedge clk);
      #1;
      if (sub_if.done) begin
        done_t.push_back(c);
        if (done_t.size() == 1) begin
          check_val("held1_diff", 32'(sub_if.diff), 32'(ref_diff(a_hist[0], b_hist[0], 0)));
        end else begin
          check_val("held2_diff", 32'(sub_if.diff),
                    32'(ref_diff(a_hist[W + 2], b_hist[W + 2], 0)));
          check_val("held2_borrow", 32'(sub_if.borrow_out),
                    32'(ref_borrow(a_hist[W + 2], b_hist[W + 2], 0)));
        end
      end
      @(negedge clk);
    end
    sub_if.start = 1'b0;
    check_val("held_npulses", 32'(done_t.size()), 2);
    if (done_t.size() >= 2) begin
      check_val("held_first", 32'(done_t[0]), 32'(W));
      check_val("held_interval", 32'(done_t[1] - done_t[0]), 32'(W + 2));
    end
    repeat (3) @(posedge clk);

    // Reset during the 4th SHIFT cycle aborts the operation.
    @(negedge clk);
    sub_if.start = 1'b1;
    sub_if.a     = 8'hC3;
    sub_if.b     = 8'h11;
    @(posedge clk);
    #1;
    sub_if.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("abort_busy", 32'(sub_if.busy), 0);
    check_val("abort_done", 32'(sub_if.done), 0);
    check_val("abort_diff", 32'(sub_if.diff), 0);
    check_val("abort_flags", 32'({sub_if.borrow_out, sub_if.overflow}), 0);
    for (int c = 0; c < W + 3; c++) begin
      @(posedge clk);
      #1;
      if (sub_if.done || sub_if.busy) check_val("abort_quiet", 32'({sub_if.done, sub_if.busy}), 0);
    end
    run_op(32'h05, 32'h03, 0, "t6");

    // Randomized operations against the reference model.
    for (int i = 0; i < 24; i++) begin
      ra   = int'($urandom_range(Mod - 1, 0));
      rb   = int'($urandom_range(Mod - 1, 0));
      rbin = int'($urandom_range(1, 0));
      run_op(ra, rb, rbin, "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
